dict_dump: RTL
==============

# dict_dump

Dictionary read-back streamer: on command, reads a contiguous byte range from the 8-bit single-port dictionary memory and emits it as a valid/ready byte stream, optionally followed by a checksum byte. It is the reader counterpart to the dictionary loader, which fills memory from a hex image. It sits between the byte-wide memory port and a host-facing byte sink (UART TX or bench monitor). It verifies dictionary contents after load or after a run of the eJ32 core.

## Interface
- ASZ, 17, memory address width in bits (128 KB space)
- CSUM, 1, when 1 a trailing checksum byte follows the data bytes
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle command strobe; sampled only in IDLE
- base_i  in  ASZ  first byte address; captured with start_i
- len_i  in  ASZ  byte count; captured with start_i; 0 is legal
- mem_addr_o  out  ASZ  memory byte address
- mem_rd_o  out  1  read request, high exactly one cycle per byte
- mem_data_i  in  8  read data, valid the cycle after mem_rd_o
- tx_data_o  out  8  stream byte
- tx_valid_o  out  1  stream byte valid
- tx_ready_i  in  1  sink accepts byte when tx_valid_o & tx_ready_i
- busy_o  out  1  high from the cycle after start_i accept until DONE
- done_o  out  1  one-cycle pulse after the last byte is accepted

## Operation
- States: IDLE, FETCH, LOAD, SEND, SUM, DONE.
- IDLE: busy_o=0. On start_i, latch addr<=base_i, cnt<=len_i, sum<=0. Next state: FETCH if len_i!=0, else SUM if CSUM, else DONE.
- FETCH: mem_addr_o=addr, mem_rd_o=1. Next state: LOAD.
- LOAD: tx_data_o<=mem_data_i, sum<=sum+mem_data_i (mod 256), tx_valid_o<=1. Next state: SEND.
- SEND: hold tx_data_o and tx_valid_o until handshake. On handshake: tx_valid_o<=0, addr<=addr+1 (mod 2^ASZ, wraps 0x1FFFF->0x00000), cnt<=cnt-1. Next state: FETCH if cnt!=1, else SUM if CSUM, else DONE.
- SUM: tx_data_o=(~sum)+1 (two's complement), tx_valid_o=1, so the data bytes plus the checksum total 0x00 mod 256. Hold until handshake. Next state: DONE.
- DONE: done_o=1 for one cycle. Next state: IDLE.
- start_i while busy_o=1 is ignored; the latched base and length are unaffected.
- mem_addr_o holds the last driven address outside FETCH; mem_rd_o=0 outside FETCH.
- Once tx_valid_o rises, it and tx_data_o stay stable until the handshake (no retraction).

## Timing
- Reset values: every output is 0; state=IDLE; addr, cnt and sum are 0.
- rst asserted in any state: next cycle is IDLE, tx_valid_o drops immediately, and no done_o pulse is generated. Stream consumers must discard the partial frame.
- Per-byte latency with tx_ready_i held high: 3 cycles (FETCH, LOAD, SEND with the handshake in SEND).
- Frame timing: start_i accepted at cycle 0 -> first FETCH at cycle 1 -> first tx_valid_o at cycle 3.
- len=N with CSUM=1 and ready held high: N*3 + 1 (SUM) + 1 (DONE) cycles after start before returning to IDLE.
- len=0 with CSUM=1: the frame is the single byte 0x00. len=0 with CSUM=0: done_o pulses 2 cycles after start_i (IDLE -> DONE -> pulse). Either way, no memory read occurs.
- Maximum length is 2^ASZ-1 bytes. The cnt width is ASZ; len is never extended.
- Backpressure: any number of tx_ready_i=0 cycles in SEND or SUM stalls without re-reading memory (exactly one mem_rd_o per data byte).

## Test plan
- Basic frame: memory 0x10..0x13 = AA 55 01 02, start with base=0x10, len=4, CSUM=1, ready=1 -> stream AA 55 01 02 FE. done_o pulses once, 15 cycles after start. Exactly 4 mem_rd_o pulses.
- Backpressure: same frame with tx_ready_i toggling 1,0,0,1,… -> identical byte sequence. tx_data_o stays stable while valid & !ready. No extra reads.
- Wrap-around: base=0x1FFFE, len=4 -> reads addresses 1FFFE, 1FFFF, 00000, 00001 in order, and the bytes match memory.
- Zero length: len=0, CSUM=1 -> single byte 0x00, then done_o. With CSUM=0 -> no tx_valid_o and done_o at start+2. mem_rd_o never asserts in either case.
- Ignored start: pulse start_i with base=0x40 mid-frame -> the current frame completes unchanged and no second frame follows.
- Reset mid-frame: assert rst during the SEND of byte 2 -> next cycle all outputs are 0 and state is IDLE, with no done_o. A new start then runs the full frame correctly.

Source files
------------

// File: rtl/dict_dump_if.sv
// Command, memory-port and byte-stream signals of the dictionary read-back streamer.
// The slave modport is the streamer; the master modport is whatever commands it and serves memory.
interface dict_dump_if #(
  parameter int ASZ = 17
);
  logic           start_i;
  logic [ASZ-1:0] base_i;
  logic [ASZ-1:0] len_i;
  logic [ASZ-1:0] mem_addr_o;
  logic           mem_rd_o;
  logic [7:0]     mem_data_i;
  logic [7:0]     tx_data_o;
  logic           tx_valid_o;
  logic           tx_ready_i;
  logic           busy_o;
  logic           done_o;

  modport slave (
    input  start_i, base_i, len_i, mem_data_i, tx_ready_i,
    output mem_addr_o, mem_rd_o, tx_data_o, tx_valid_o, busy_o, done_o
  );

  modport master (
    output start_i, base_i, len_i, mem_data_i, tx_ready_i,
    input  mem_addr_o, mem_rd_o, tx_data_o, tx_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/dict_dump.sv
// Streams a contiguous byte range of the dictionary memory out over valid/ready,
// optionally followed by a two's-complement checksum byte.
module dict_dump #(
  parameter int ASZ  = 17,
  parameter bit CSUM = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  dict_dump_if.slave  bus,
  output logic [2:0]  dbg_state_o
);

  // Stream handshake: a byte transfers on a rising edge where tx_valid_o & tx_ready_i;
  // once tx_valid_o is raised, it and tx_data_o hold until that transfer happens.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SEND  = 3'd3,
    S_SUM   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [ASZ-1:0] addr_q, addr_d;
  logic [ASZ-1:0] cnt_q, cnt_d;
  logic [ASZ-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]     sum_q, sum_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_valid_q, tx_valid_d;
  logic           done_q, done_d;
  logic           hs;

  assign hs = tx_valid_q & bus.tx_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      sum_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      sum_q      <= sum_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          if (bus.len_i != '0) state_d = S_FETCH;
          else if (CSUM)       state_d = S_SUM;
          else                 state_d = S_DONE;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_SEND;
      S_SEND: begin
        if (hs) begin
          if (cnt_q != ASZ'(1)) state_d = S_FETCH;
          else if (CSUM)        state_d = S_SUM;
          else                  state_d = S_DONE;
        end
      end
      S_SUM:   if (hs) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    sum_d      = sum_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          addr_d = bus.base_i;
          cnt_d  = bus.len_i;
          sum_d  = 8'h00;
        end
      end
      S_LOAD: begin
        tx_data_d  = bus.mem_data_i;
        sum_d      = sum_q + bus.mem_data_i;
        tx_valid_d = 1'b1;
      end
      S_SEND: begin
        if (hs) begin
          tx_valid_d = 1'b0;
          addr_d     = addr_q + ASZ'(1);
          cnt_d      = cnt_q - ASZ'(1);
        end
      end
      S_SUM:   if (hs) tx_valid_d = 1'b0;
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
    // The address port only moves when a fetch begins, so it holds between reads.
    if (state_d == S_FETCH && state_q != S_FETCH) mem_addr_d = addr_d;
    if (state_d == S_SUM && state_q != S_SUM) begin
      tx_data_d  = 8'(~sum_d + 8'd1);
      tx_valid_d = 1'b1;
    end
  end

  always_comb begin
    bus.mem_rd_o   = (state_q == S_FETCH);
    bus.mem_addr_o = mem_addr_q;
    bus.tx_data_o  = tx_data_q;
    bus.tx_valid_o = tx_valid_q;
    bus.busy_o     = (state_q != S_IDLE);
    bus.done_o     = done_q;
    dbg_state_o    = state_q;
  end

endmodule
